// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer:
// FSM state encoding, PC increment step and default vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

    // Redirect priority: jump wins over a taken branch, otherwise fall through.
    function automatic logic [31:0] select_next(
        input logic        jump,
        input logic [31:0] jump_target,
        input logic        branch_taken,
        input logic [31:0] branch_target,
        input logic [31:0] pc_plus4
    );
        if (jump)
            return jump_target;
        else if (branch_taken)
            return branch_target;
        else
            return pc_plus4;
    endfunction

endpackage

// File: rtl/pc_seq_incr.sv
// pc_incr: 32-bit sequential-address adder, pc + PC_STEP, wrapping modulo 2^32.
module pc_incr
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + PC_STEP;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a BOOT/FETCH/HOLD fetch FSM.
// Optional macro MISALIGN_TRAP_EN: misaligned next_pc redirects to TRAP_VECTOR and pulses trap.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
`ifdef MISALIGN_TRAP_EN
    output logic        trap,
`endif
    output logic [1:0]  fsm_state
);

    // Fetch handshake: imem_req is the valid, imem_ack is the ready; a fetch
    // completes on a rising edge where both are high, and the request (with
    // imem_addr held at pc) stays up until that edge.  Acks while imem_req is
    // low are ignored.

    pc_state_t   state;
    logic [31:0] next_sel;
    logic [31:0] next_pc;
    logic        advance;

    pc_incr u_incr (
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign next_sel = select_next(jump, jump_target, branch_taken, branch_target, pc_plus4);

    // Redirect inputs only matter on edges where pc actually moves.
    assign advance = ((state == FETCH) && imem_ack && !stall) ||
                     ((state == HOLD) && !stall);

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (next_sel[1:0] != 2'b00);
    assign next_pc    = misaligned ? TRAP_VECTOR : next_sel;
`else
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
    assign next_pc            = next_sel & ~32'h0000_0003;
`endif

    assign imem_addr   = pc;
    assign instr_valid = (state == FETCH) && imem_ack;
    assign fsm_state   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            imem_req <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap     <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            trap <= advance && misaligned;
`endif
            if (advance)
                pc <= next_pc;

            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack && stall) begin
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [1:0]  fsm_state;
`ifdef MISALIGN_TRAP_EN
    logic        trap;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic        m_boot;
    logic        m_parked;
    logic [31:0] m_pc;
    logic        m_trap;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
`ifdef MISALIGN_TRAP_EN
        .trap          (trap),
`endif
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- clock / reset helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        jump_target = 32'd0; branch_target = 32'd0;
    endtask

    // Leaves the DUT in its BOOT cycle, just after reset release.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // From the BOOT cycle, use one jump fetch to park the DUT in FETCH at target.
    task automatic goto_pc(input logic [31:0] target);
        imem_ack = 1'b1; jump = 1'b1; jump_target = target;
        tick();
        tick();
        clear_inputs();
    endtask

    // ---------------- reference model ----------------
    // A fetch completes when the fetcher is active and ack is high; moving on
    // picks the highest-priority redirect, else the next word.
    task automatic model_step(input logic s, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt, input logic a);
        logic        move;
        logic [31:0] dest;
        move   = 1'b0;
        m_trap = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_parked) begin
            if (!s) begin move = 1'b1; m_parked = 1'b0; end
        end else if (a) begin
            if (s) m_parked = 1'b1;
            else   move = 1'b1;
        end
        if (move) begin
            dest = j ? jt : (b ? bt : m_pc + 32'd4);
`ifdef MISALIGN_TRAP_EN
            if (dest % 4 != 0) begin
                m_pc   = 32'h0000_0080;
                m_trap = 1'b1;
            end else begin
                m_pc = dest;
            end
`else
            m_pc = dest - (dest % 4);
`endif
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        rst = 1'b1;
        imem_ack = 1'b1; jump = 1'b1; jump_target = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pc !== 32'h0 || fsm_state !== BOOT || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: pc=%h state=%0d req=%b valid=%b, required pc=0 state=0 req=0 valid=0",
                     pc, fsm_state, imem_req, instr_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0; jump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pc !== exp_pc[i] || imem_req !== (i != 0) || instr_valid !== (i != 0)) begin
                errors++;
                $display("FAIL boot_seq[%0d]: pc=%h req=%b valid=%b, required pc=%h req=%b valid=%b",
                         i, pc, imem_req, instr_valid, exp_pc[i], (i != 0), (i != 0));
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        goto_pc(32'h8);
        imem_ack = 1'b1;
        jump = 1'b1; jump_target = 32'h100;
        branch_taken = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        checks++;
        if (pc !== 32'h8 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL prio_pre: pc=%h valid=%b, required pc=00000008 valid=1", pc, instr_valid);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL prio_jump: pc=%h, required 00000100", pc);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        goto_pc(32'h10);
        imem_ack = 1'b1; stall = 1'b1;
        @(negedge clk);
        checks++;
        if (pc !== 32'h10 || instr_valid !== 1'b1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_entry: pc=%h valid=%b req=%b, required pc=00000010 valid=1 req=1",
                     pc, instr_valid, imem_req);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            stall = (i < 2);
            jump = (i < 2); jump_target = 32'h300;
            branch_taken = (i == 2); branch_target = 32'h40;
            imem_ack = 1'b1;
            @(negedge clk);
            checks++;
            if (pc !== 32'h10 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fsm_state !== HOLD) begin
                errors++;
                $display("FAIL hold[%0d]: pc=%h req=%b valid=%b state=%0d, required pc=00000010 req=0 valid=0 state=2",
                         i, pc, imem_req, instr_valid, fsm_state);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (pc !== 32'h40 || fsm_state !== FETCH || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: pc=%h state=%0d req=%b, required pc=00000040 state=1 req=1",
                     pc, fsm_state, imem_req);
        end
        tick();
    endtask

    task automatic test_no_ack();
        do_reset();
        goto_pc(32'h20);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b0;
            stall = 1'($urandom_range(0, 1));
            jump = 1'(i % 2); jump_target = $urandom & ~32'h3;
            branch_taken = 1'((i + 1) % 2); branch_target = $urandom & ~32'h3;
            @(negedge clk);
            checks++;
            if (pc !== 32'h20 || imem_addr !== 32'h20 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL no_ack[%0d]: pc=%h addr=%h valid=%b req=%b, required pc=addr=00000020 valid=0 req=1",
                         i, pc, imem_addr, instr_valid, imem_req);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_misalign();
        do_reset();
        goto_pc(32'h8);
        imem_ack = 1'b1; jump = 1'b1; jump_target = 32'h102;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
`ifdef MISALIGN_TRAP_EN
        if (pc !== 32'h80 || trap !== 1'b1) begin
            errors++;
            $display("FAIL misalign_trap: pc=%h trap=%b, required pc=00000080 trap=1", pc, trap);
        end
        tick();
        @(negedge clk);
        checks++;
        if (trap !== 1'b0) begin
            errors++;
            $display("FAIL trap_pulse: trap=%b, required 0", trap);
        end
`else
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL misalign_force: pc=%h, required 00000100", pc);
        end
`endif
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        goto_pc(32'hFFFF_FFFC);
        @(negedge clk);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus4: pc=%h pc_plus4=%h, required fffffffc 00000000", pc, pc_plus4);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h, required 00000000", pc);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        goto_pc(32'h40);
        imem_ack = 1'b1; stall = 1'b1;
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h0 || fsm_state !== BOOT || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: pc=%h state=%0d req=%b valid=%b, required pc=0 state=0 req=0 valid=0",
                     pc, fsm_state, imem_req, instr_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (fsm_state !== BOOT || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_after_rst: state=%0d valid=%b req=%b, required state=0 valid=0 req=0",
                     fsm_state, instr_valid, imem_req);
        end
        tick();
        @(negedge clk);
        checks++;
        if (fsm_state !== FETCH || pc !== 32'h0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL refetch: state=%0d pc=%h valid=%b, required state=1 pc=0 valid=1",
                     fsm_state, pc, instr_valid);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic exp_req;
        do_reset();
        m_boot = 1'b1; m_parked = 1'b0; m_pc = 32'h0; m_trap = 1'b0;
        for (int i = 0; i < 600; i++) begin
            imem_ack     = ($urandom_range(0, 9) < 7);
            stall        = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 6) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            jump_target   = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & ~32'h3);
            branch_target = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & ~32'h3);
            @(negedge clk);
            exp_req = !m_boot && !m_parked;
            checks++;
            if (pc !== m_pc || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
                imem_req !== exp_req || instr_valid !== (exp_req && imem_ack)) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h addr=%h plus4=%h req=%b valid=%b, required pc=%h req=%b valid=%b",
                         i, pc, imem_addr, pc_plus4, imem_req, instr_valid, m_pc, exp_req, exp_req && imem_ack);
            end
`ifdef MISALIGN_TRAP_EN
            checks++;
            if (trap !== m_trap) begin
                errors++;
                $display("FAIL random_trap[%0d]: trap=%b, required %b", i, trap, m_trap);
            end
`endif
            model_step(stall, jump, jump_target, branch_taken, branch_target, imem_ack);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall();
        test_no_ack();
        test_misalign();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: the PC value loaded by reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0080: the PC value loaded on a misaligned-target trap.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 stall  input  1: while high, the PC is held after the current fetch completes.
REQ-006 jump  input  1: selects jump_target as the next PC.
REQ-007 jump_target  input  32: jump destination.
REQ-008 branch_taken  input  1: selects branch_target as the next PC when jump is low.
REQ-009 branch_target  input  32: branch destination.
REQ-010 imem_ack  input  1: instruction memory has returned the instruction at imem_addr this cycle.
REQ-011 imem_req  output  1: fetch request to instruction memory.
REQ-012 imem_addr  output  32: fetch address; always equal to pc.
REQ-013 pc  output  32: current program counter.
REQ-014 pc_plus4  output  32: combinational pc + 4, modulo 2^32.
REQ-015 instr_valid  output  1: one-cycle pulse, coincident with imem_ack accepted in FETCH.
REQ-016 trap  output  1: one-cycle misaligned-target pulse; present only when MISALIGN_TRAP_EN is defined.

Function
REQ-017 The FSM SHALL have three states: BOOT, FETCH and HOLD.
REQ-018 BOOT: imem_req=0; the FSM moves to FETCH unconditionally on the next edge; pc remains RESET_VECTOR.
REQ-019 FETCH: imem_req=1; without imem_ack, pc holds and the FSM stays in FETCH.
REQ-020 FETCH with imem_ack: instr_valid=1 that cycle.
REQ-021 FETCH with imem_ack and stall=0: pc <= next_pc on the same edge; the FSM stays in FETCH, giving back-to-back fetches with zero bubble.
REQ-022 FETCH with imem_ack and stall=1: pc holds and the FSM enters HOLD.
REQ-023 HOLD: imem_req=0 and instr_valid=0; while stall=1, the FSM stays in HOLD.
REQ-024 HOLD with stall=0: pc <= next_pc; the FSM returns to FETCH.
REQ-025 next_pc priority: jump -> jump_target; else branch_taken -> branch_target; else pc_plus4.
REQ-026 jump and branch_taken SHALL be sampled only on an edge where pc advances (REQ-021, REQ-024); at all other times they are ignored.
REQ-027 Incrementing 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no flag.
REQ-028 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-029 While rst is asserted, regardless of clk: state=BOOT, pc=RESET_VECTOR, imem_req=0, instr_valid=0, trap=0.
REQ-030 Reset asserted mid-fetch SHALL abandon the outstanding request; an ack arriving after reset SHALL be ignored until the FSM re-enters FETCH.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN defined: if the selected next_pc[1:0] != 2'b00, then pc <= TRAP_VECTOR and trap pulses high for one cycle on that same update.
REQ-032 Macro MISALIGN_TRAP_EN undefined: next_pc[1:0] is forced to 2'b00, and the trap port and its logic are absent.

Structure
REQ-033 Shared package pc_seq_pkg SHALL hold the state enum (BOOT, FETCH, HOLD), PC_STEP=32'd4, and the default RESET_VECTOR and TRAP_VECTOR constants.
REQ-034 A single sub-module, pc_incr (32-bit pc + PC_STEP), SHALL produce pc_plus4; all other logic lives in pc_sequencer.

Verification
REQ-035 Reset release, imem_ack tied high, no redirects -> pc sequence 0x0, 0x0 (BOOT), 0x4, 0x8, 0xC, with instr_valid high on every FETCH cycle.
REQ-036 At pc=0x8 with ack: jump=1 (jump_target=0x100) and branch_taken=1 (branch_target=0x200) in the same cycle -> pc=0x100 next cycle.
REQ-037 At pc=0x10: ack with stall=1 held 3 cycles and branch_taken=1 (branch_target=0x40) in the release cycle -> pc=0x10 for 3 HOLD cycles with imem_req=0, then pc=0x40.
REQ-038 FETCH with imem_ack low for 4 cycles, redirects toggling -> pc and imem_addr stay constant and instr_valid=0.
REQ-039 MISALIGN_TRAP_EN defined, jump_target=0x102 -> pc=0x80 and a single trap pulse; undefined, same stimulus -> pc=0x100 and no trap port.
REQ-040 pc=0xFFFF_FFFC with ack, and rst pulsed mid-HOLD in a separate run -> pc=0x0 on wrap; rst immediately forces pc=RESET_VECTOR, state=BOOT and imem_req=0.
